// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register bank.
// Frame layout: R/W bit, address, data, MSB first.
package spi_reg_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      CHECK = 2'd2
   } state_t;

   localparam logic RW_WRITE  = 1'b1;
   localparam logic RW_READ   = 1'b0;
   localparam int   ERR_CNT_W = 8;

   function automatic int frame_width(input int addr_w, input int data_w);
      return 1 + addr_w + data_w;
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for an asynchronous input, producing registered
// one-cycle rise and fall pulses in the clk domain.
module spi_sync_edge #(
   parameter int   STAGES = 2,
   parameter logic INIT   = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic chain_reg [STAGES];
   logic dly_reg;
   logic rise_reg;
   logic fall_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) chain_reg[0] <= INIT;
      else        chain_reg[0] <= din;
   end

   genvar gi;
   generate
      for (gi = 1; gi < STAGES; gi++) begin : g_stage
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) chain_reg[gi] <= INIT;
            else        chain_reg[gi] <= chain_reg[gi-1];
         end
      end
   endgenerate

   // Pulses are registered so they line up with the delayed level in dly_reg.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dly_reg  <= INIT;
         rise_reg <= 1'b0;
         fall_reg <= 1'b0;
      end else begin
         dly_reg  <= chain_reg[STAGES-1];
         rise_reg <= chain_reg[STAGES-1] & ~dly_reg;
         fall_reg <= ~chain_reg[STAGES-1] & dly_reg;
      end
   end

   assign rise = rise_reg;
   assign fall = fall_reg;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 register bank with frame validation and error counting.
// Define SPI_READBACK_EN to return register contents on cipo during read frames.
module spi_reg_bank
   import spi_reg_pkg::*;
#(
   parameter int NUM_REGS    = 5,
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 7,
   parameter int SYNC_STAGES = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         sclk,
   input  logic                         copi,
   input  logic                         ncs,
   output logic                         cipo,
   output logic                         cipo_oe,
   output logic [NUM_REGS*DATA_W-1:0]   regs_q,
   output logic [NUM_REGS-1:0]          wr_strobe,
   output logic                         frame_err,
   output logic [ERR_CNT_W-1:0]         err_count,
   output logic                         busy
);

   localparam int FRAME_W = frame_width(ADDR_W, DATA_W);
   localparam int CNT_W   = $clog2(FRAME_W + 2);
   localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(FRAME_W);
   localparam logic [CNT_W-1:0]  CNT_SAT    = CNT_W'(FRAME_W + 1);
   localparam logic [CNT_W-1:0]  CNT_HDR    = CNT_W'(1 + ADDR_W);
   localparam logic [ADDR_W:0]   NUM_REGS_C = (ADDR_W + 1)'(NUM_REGS);

   logic sclk_rise, sclk_fall, ncs_rise, ncs_fall;
   logic copi_chain_reg [SYNC_STAGES+1];
   logic copi_s;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sclk_sync (
      .clk(clk), .rst_n(rst_n), .din(sclk), .rise(sclk_rise), .fall(sclk_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_ncs_sync (
      .clk(clk), .rst_n(rst_n), .din(ncs), .rise(ncs_rise), .fall(ncs_fall)
   );

   // One stage longer than the synchroniser so copi aligns with the edge pulses.
   genvar gi;
   generate
      for (gi = 0; gi <= SYNC_STAGES; gi++) begin : g_copi
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)       copi_chain_reg[gi] <= 1'b0;
            else if (gi == 0) copi_chain_reg[gi] <= copi;
            else              copi_chain_reg[gi] <= copi_chain_reg[(gi == 0) ? 0 : gi-1];
         end
      end
   endgenerate
   assign copi_s = copi_chain_reg[SYNC_STAGES];

   state_t                    state_reg, state_next;
   logic [CNT_W-1:0]          count_reg, count_next;
   logic [FRAME_W-1:0]        shift_reg, shift_next;
   logic                      pending_reg, pending_next;
   logic                      wr_en, err_en;
   logic                      frame_rw;
   logic [ADDR_W-1:0]         frame_addr;
   logic [DATA_W-1:0]         frame_data;
   logic                      addr_ok;
   logic                      frame_err_reg;
   logic [ERR_CNT_W-1:0]      err_count_reg;
   logic [DATA_W-1:0]         regs_arr [NUM_REGS];
   logic                      strobe_reg [NUM_REGS];

   assign frame_rw   = shift_reg[FRAME_W-1];
   assign frame_addr = shift_reg[DATA_W +: ADDR_W];
   assign frame_data = shift_reg[DATA_W-1:0];
   assign addr_ok    = {1'b0, frame_addr} < NUM_REGS_C;

   always_comb begin
      state_next   = state_reg;
      count_next   = count_reg;
      shift_next   = shift_reg;
      pending_next = pending_reg;
      wr_en        = 1'b0;
      err_en       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (ncs_fall || pending_reg) begin
               state_next   = SHIFT;
               count_next   = '0;
               shift_next   = '0;
               pending_next = 1'b0;
            end
         end
         SHIFT: begin
            // A simultaneous ncs rise ends the frame and drops the sclk bit.
            if (ncs_rise) begin
               state_next = CHECK;
            end else if (sclk_rise && count_reg != CNT_SAT) begin
               count_next = count_reg + 1'b1;
               if (count_reg != CNT_FULL)
                  shift_next = {shift_reg[FRAME_W-2:0], copi_s};
            end
         end
         CHECK: begin
            state_next = IDLE;
            if (ncs_fall) pending_next = 1'b1;
            if (count_reg == CNT_FULL) begin
               if (frame_rw == RW_WRITE) begin
                  if (addr_ok) wr_en  = 1'b1;
                  else         err_en = 1'b1;
               end
            end else if (count_reg != '0) begin
               err_en = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         count_reg     <= '0;
         shift_reg     <= '0;
         pending_reg   <= 1'b0;
         frame_err_reg <= 1'b0;
         err_count_reg <= '0;
      end else begin
         state_reg     <= state_next;
         count_reg     <= count_next;
         shift_reg     <= shift_next;
         pending_reg   <= pending_next;
         frame_err_reg <= err_en;
         if (err_en && err_count_reg != {ERR_CNT_W{1'b1}})
            err_count_reg <= err_count_reg + 1'b1;
      end
   end

   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               regs_arr[gi]   <= '0;
               strobe_reg[gi] <= 1'b0;
            end else begin
               strobe_reg[gi] <= wr_en && (frame_addr == ADDR_W'(gi));
               if (wr_en && (frame_addr == ADDR_W'(gi)))
                  regs_arr[gi] <= frame_data;
            end
         end
         assign regs_q[gi*DATA_W +: DATA_W] = regs_arr[gi];
         assign wr_strobe[gi]               = strobe_reg[gi];
      end
   endgenerate

   assign frame_err = frame_err_reg;
   assign err_count = err_count_reg;
   assign busy      = (state_reg != IDLE);

`ifdef SPI_READBACK_EN
   logic              rw_reg, loaded_reg, cipo_reg;
   logic [DATA_W-1:0] out_shift_reg, rd_data;
   logic              oe_int;

   // Once the header is in, its address sits in the low bits of the shifter.
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_REGS; i++)
         if (shift_reg[ADDR_W-1:0] == ADDR_W'(i)) rd_data = regs_arr[i];
   end

   assign oe_int = (state_reg == SHIFT) && (rw_reg == RW_READ) && (count_reg >= CNT_HDR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rw_reg        <= RW_WRITE;
         loaded_reg    <= 1'b0;
         cipo_reg      <= 1'b0;
         out_shift_reg <= '0;
      end else begin
         if (state_reg == IDLE && state_next == SHIFT) begin
            rw_reg     <= RW_WRITE;
            loaded_reg <= 1'b0;
            cipo_reg   <= 1'b0;
         end
         if (state_reg == SHIFT && sclk_rise && !ncs_rise && count_reg == '0)
            rw_reg <= copi_s;
         if (state_reg == SHIFT && count_reg == CNT_HDR && rw_reg == RW_READ && !loaded_reg) begin
            out_shift_reg <= rd_data;
            loaded_reg    <= 1'b1;
         end else if (oe_int && sclk_fall) begin
            cipo_reg      <= out_shift_reg[DATA_W-1];
            out_shift_reg <= out_shift_reg << 1;
         end
         if (state_reg == CHECK) cipo_reg <= 1'b0;
      end
   end

   assign cipo    = cipo_reg;
   assign cipo_oe = oe_int;
`else
   logic unused_sclk_fall;
   assign unused_sclk_fall = sclk_fall;
   assign cipo    = 1'b0;
   assign cipo_oe = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed self-checking bench for spi_reg_bank at default parameters.
// Honours SPI_READBACK_EN for the read-frame checks.
module tb_spi_reg_bank;

   localparam int HALF = 6;

   logic        clk = 1'b0;
   logic        rst_n, sclk, copi, ncs;
   logic        cipo, cipo_oe, frame_err, busy;
   logic [39:0] regs_q;
   logic [4:0]  wr_strobe;
   logic [7:0]  err_count;

   int tests = 0;
   int fails = 0;
   int strobe_cycles = 0;
   int err_pulses = 0;
   logic [4:0] last_strobe = '0;
   int lat;
   int last_oe;
   logic [31:0] last_rx;

   spi_reg_bank dut (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
      .cipo(cipo), .cipo_oe(cipo_oe), .regs_q(regs_q), .wr_strobe(wr_strobe),
      .frame_err(frame_err), .err_count(err_count), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_strobe != 0) begin
         strobe_cycles++;
         last_strobe = wr_strobe;
      end
      if (frame_err) err_pulses++;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic shift_bits(input logic [31:0] frame, input int n);
      logic [31:0] rx;
      int oe_bits;
      rx = '0;
      oe_bits = 0;
      for (int i = n - 1; i >= 0; i--) begin
         copi = frame[i];
         wait_clks(HALF);
         rx = {rx[30:0], cipo};
         if (cipo_oe) oe_bits++;
         sclk = 1'b1;
         wait_clks(HALF);
         sclk = 1'b0;
      end
      last_rx = rx;
      last_oe = oe_bits;
   endtask

   task automatic send_frame(input logic [31:0] frame, input int n);
      ncs = 1'b0;
      wait_clks(HALF);
      shift_bits(frame, n);
      wait_clks(HALF);
      ncs = 1'b1;
      lat = -1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (lat < 0 && (wr_strobe != 0 || frame_err)) lat = k;
      end
      $display("[TB] frame %0h (%0d bits): regs_q=%h err_count=%0d lat=%0d",
               frame, n, regs_q, err_count, lat);
   endtask

   initial begin
      int s0, e0;
      rst_n = 1'b0; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
      wait_clks(4);
      check("rst_regs_q", regs_q, 0);
      check("rst_wr_strobe", wr_strobe, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_err_count", err_count, 0);
      check("rst_cipo", {cipo, cipo_oe}, 0);
      check("rst_busy", busy, 0);
      rst_n = 1'b1;
      wait_clks(4);

      // Single write to reg1
      s0 = strobe_cycles;
      send_frame(32'h81A5, 16);
      check("w1_regs_q", regs_q, 40'h00_0000_A500);
      check("w1_strobe_cycles", strobe_cycles - s0, 1);
      check("w1_strobe_value", last_strobe, 5'b00010);
      check("w1_latency", lat, 5);
      check("w1_err_count", err_count, 0);
      check("w1_busy", busy, 0);

      // Five back-to-back writes
      s0 = strobe_cycles;
      for (int a = 0; a < 5; a++)
         send_frame(32'h8000 | (a << 8) | (32'h11 * (a + 1)), 16);
      check("w5_regs_q", regs_q, 40'h55_4433_2211);
      check("w5_strobe_cycles", strobe_cycles - s0, 5);
      check("w5_last_strobe", last_strobe, 5'b10000);
      check("w5_err_count", err_count, 0);

      // Bad address, short frame, long frame
      s0 = strobe_cycles;
      e0 = err_pulses;
      send_frame(32'h85FF, 16);
      check("bad_addr_latency", lat, 5);
      send_frame(32'h40D2, 15);
      send_frame(32'h1034A, 17);
      check("bad_regs_q", regs_q, 40'h55_4433_2211);
      check("bad_err_pulses", err_pulses - e0, 3);
      check("bad_err_count", err_count, 3);
      check("bad_strobes", strobe_cycles - s0, 0);

      // Empty frame is discarded silently
      e0 = err_pulses;
      send_frame(32'h0, 0);
      check("empty_err_pulses", err_pulses - e0, 0);
      check("empty_err_count", err_count, 3);

      // Reset in the middle of a frame
      ncs = 1'b0;
      wait_clks(HALF);
      shift_bits(32'h81, 8);
      rst_n = 1'b0;
      ncs = 1'b1;
      wait_clks(4);
      check("mid_rst_regs_q", regs_q, 0);
      check("mid_rst_err_count", err_count, 0);
      check("mid_rst_busy", busy, 0);
      rst_n = 1'b1;
      wait_clks(4);
      send_frame(32'h8042, 16);
      check("post_rst_regs_q", regs_q, 40'h00_0000_0042);

      // Write reg2 then read it back
      send_frame(32'h823C, 16);
      check("rd_setup_regs_q", regs_q, 40'h00_003C_0042);
      s0 = strobe_cycles;
      e0 = err_pulses;
      send_frame(32'h0200, 16);
      check("rd_no_write", regs_q, 40'h00_003C_0042);
      check("rd_no_strobe", strobe_cycles - s0, 0);
      check("rd_no_err", err_pulses - e0, 0);
`ifdef SPI_READBACK_EN
      check("rd_cipo_data", last_rx[7:0], 8'h3C);
      check("rd_oe_bits", last_oe, 8);
`else
      check("rd_cipo_tied", last_rx, 0);
      check("rd_oe_tied", last_oe, 0);
`endif
      check("rd_oe_after", cipo_oe, 0);

      // Error counter saturation with one-bit frames
      e0 = err_pulses;
      for (int k = 0; k < 254; k++) send_frame(32'h1, 1);
      check("sat_254", err_count, 254);
      send_frame(32'h1, 1);
      check("sat_255", err_count, 255);
      send_frame(32'h1, 1);
      check("sat_hold", err_count, 255);
      check("sat_pulse_latency", lat, 5);
      check("sat_err_pulses", err_pulses - e0, 256);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/spi_reg_bank.md
# spi_reg_bank

Parametrised SPI-mode-0 register bank. It is the next generation of the fixed five-register SPI write peripheral that drives the output-enable, PWM-enable and duty-cycle registers. It generalises register count and data width, validates every frame, and reports errors. With `SPI_READBACK_EN` defined, it also returns register contents on CIPO. It sits between the chip's SPI pins and the PWM/output logic, in the system `clk` domain.

## Interface
Parameters:
- `NUM_REGS`, default 5: number of registers; legal range 1..2**ADDR_W.
- `DATA_W`, default 8: register width.
- `ADDR_W`, default 7: address field width.
- `SYNC_STAGES`, default 2: synchroniser depth (≥2) on `sclk`, `copi` and `ncs`.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1: system clock.
- `rst_n`  in  1: asynchronous active-low reset.
- `sclk`  in  1: SPI clock from controller (asynchronous).
- `copi`  in  1: SPI data from controller.
- `ncs`  in  1: chip select, active low.
- `cipo`  out  1: SPI data to controller.
- `cipo_oe`  out  1: CIPO drive enable.
- `regs_q`  out  NUM_REGS*DATA_W: register contents, reg i at bits [i*DATA_W +: DATA_W].
- `wr_strobe`  out  NUM_REGS: one-cycle pulse on the written register.
- `frame_err`  out  1: one-cycle pulse when a frame is rejected.
- `err_count`  out  8: count of rejected frames, saturating at 255.
- `busy`  out  1: high while a frame is in progress.

## Operation
- Frame is MSB first, `FRAME_W = 1 + ADDR_W + DATA_W` bits (16 at defaults): R/W bit (1 = write), then address, then data.
- `copi` is sampled on the synchronised `sclk` rising edge.
- FSM:
  - IDLE → SHIFT on synchronised `ncs` falling edge. Clears the shift register and the bit counter.
  - SHIFT: each sclk rise shifts in one bit. The counter saturates at FRAME_W+1. Bits beyond FRAME_W are not shifted in.
  - SHIFT → CHECK on synchronised `ncs` rising edge.
  - CHECK → IDLE after one cycle. The frame is accepted only if count == FRAME_W, R/W = 1 and address < NUM_REGS. On accept: write `DATA_W` bits into reg[addr] and pulse `wr_strobe[addr]`.
  - Any other CHECK outcome: pulse `frame_err` and increment `err_count` (saturating). Exception: count == 0 discards silently, with no error.
  - A read frame (R/W = 0) with count == FRAME_W is valid: no write, no error.
- `ncs` rise and `sclk` rise detected in the same cycle: `ncs` wins, and that bit is dropped.
- `ncs` fall while in CHECK: handled on return to IDLE is not allowed. The falling edge is latched and IDLE → SHIFT happens in the next cycle, so no frame is lost.
- `busy` = state ≠ IDLE.
- Reset, including mid-frame: all registers 0, `regs_q` 0, `wr_strobe` 0, `frame_err` 0, `err_count` 0, `cipo` 0, `cipo_oe` 0, state IDLE. A partial frame is lost.

## Timing
- Input latency: SYNC_STAGES clk cycles, plus 1 cycle for edge detect.
- Register update, `wr_strobe` and `frame_err` occur SYNC_STAGES+2 clk edges after the first clk edge that samples `ncs` high.
- `regs_q` is registered and holds its value between writes.
- Requirement: sclk high and low times each ≥ SYNC_STAGES+2 clk periods. `ncs` setup and hold to the first and last sclk edge ≥ SYNC_STAGES+2 clk periods.

## Configuration
- `SPI_READBACK_EN` defined:
  - When count reaches 1+ADDR_W with R/W = 0, load `reg[addr]` into the output shifter. An out-of-range address loads 0.
  - `cipo` presents the data MSB first, updated on each synchronised sclk falling edge.
  - `cipo_oe` = SHIFT state and R/W = 0 and count ≥ 1+ADDR_W.
- `SPI_READBACK_EN` undefined: `cipo` and `cipo_oe` are tied 0, and the output shifter is absent.

## Structure
- Package `spi_reg_pkg`: state enum (IDLE, SHIFT, CHECK), FRAME_W computation function, R/W encoding constants, ERR_CNT_W = 8.
- Sub-module `spi_sync_edge`: SYNC_STAGES-deep synchroniser with rise and fall pulse outputs. Instantiated for `sclk` and `ncs`; `copi` uses its synchronised output only.

## Test plan
- Write 0x01 / 0xA5 (frame 0x81A5) → reg1 = 0xA5, `wr_strobe` = 5'b00010 for one cycle, other registers unchanged.
- Five back-to-back writes to addresses 0..4 with 0x11..0x55 → `regs_q` = 0x5544332211, `err_count` = 0.
- Write to address 5 (frame 0x85FF); then a 15-bit frame; then a 17-bit frame → no register change, three `frame_err` pulses, `err_count` = 3.
- Assert reset mid-frame after 8 bits, release, send frame 0x8042 → all registers 0 after reset, then reg0 = 0x42.
- `SPI_READBACK_EN`: write reg2 = 0x3C, then read frame 0x02xx → `cipo` shifts 0x3C during the data bits, `cipo_oe` high only during those 8 bits, no write and no error.
- 256 invalid frames → `err_count` saturates at 255, `frame_err` still pulses.
